pipelined_memory: RTL and testbench
===================================

Name: pipelined_memory

Overview:
- Byte-addressed, big-endian data memory with a parametrised word width and depth, and a configurable read latency.
- Takes requests on a valid/ready port. Returns exactly one in-order response per accepted request, also on a valid/ready port.
- Writes are bit-masked and also return the pre-write word.
- Sits between the CPU load/store unit and backing RAM, replacing the single-cycle combinational-read memory.

Parameters:
- W, 32, word width in bits; multiple of 8, 16..128; B = W/8 bytes per word
- M, 10, log2 of word count; storage is B*2^M bytes
- LAT, 1, cycles from request accept to response valid; legal range 1..4

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; transfer when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  log2(B)+M  byte address
- req_mask  in  W  per-bit write mask; 1 = overwrite, 0 = keep
- req_wdata  in  W  write data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts; transfer when resp_valid && resp_ready
- resp_rdata  out  W  read data (reads) or pre-write word (writes)
- resp_err  out  1  misaligned-access error (see Optional Feature)

Behaviour:
- Byte order: big-endian. The byte at the word base address maps to bits [W-1:W-8]; base+B-1 maps to [7:0].
- Storage: byte array, zero-initialised at elaboration. rst does NOT clear contents.
- Accept (write): on accept cycle edge, each storage bit becomes (old & ~mask) | (wdata & mask). The old word is captured as response data in the same edge.
- Accept (read): the word at the aligned address is captured into stage 1 in the accept cycle.
- Ordering: a read accepted the cycle after a write to the same word sees the new data. No other hazards exist.
- Pipeline: LAT stages, each holding valid, rdata and err. A response reaches resp_valid exactly LAT cycles after accept when no stall occurs.
- Stall: stall = resp_valid && !resp_ready. When stalled, all stages hold and req_ready = 0. Otherwise req_ready = 1.
- Output stability: while resp_valid && !resp_ready, resp_rdata and resp_err are held stable.
- Throughput: one request per cycle with resp_ready held high.
- Bubbles: stage valids are independent; bubbles propagate and are not collapsed.
- Reset: while rst = 1, req_ready = 0, no write occurs, and all stage valids clear. Next cycle: resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Reset mid-operation: in-flight responses are dropped. Writes already committed remain in storage.
- Address: full address width is used, with no out-of-range case. The top word is 2^M-1; there is no wrap within a word.
- Idle: with req_valid = 0, stages shift bubbles and resp_valid falls once drained.

Optional Feature:
- Macro: PIPELINED_MEMORY_ALIGN_ERR_EN
- Defined: an access with addr[log2(B)-1:0] != 0 is still accepted and still produces a response. No storage change occurs; resp_rdata = 0 and resp_err = 1.
- Undefined: low address bits are ignored and the access is treated as aligned. resp_err is tied 0.

Decomposition:
- Package pipelined_memory_pkg holds:
  - localparam functions for B and address width
  - typedef struct mem_resp_t {logic err; logic [W-1:0] rdata;}, parametrised via a W-sized typedef in the including module
  - legal-LAT assertion constant
- Sub-module mem_pipe_stage: one register stage (valid + payload, hold on stall, clear on rst). It is instantiated LAT times in a generate loop.

Test Plan:
1. W=32, M=10, LAT=1: write addr 0x10, mask 0xFFFFFFFF, wdata 0xDEADBEEF, then read 0x10. Required: write response rdata 0x00000000; read response 0xDEADBEEF one cycle after accept; byte 0x10 = 0xDE, byte 0x13 = 0xEF.
2. Masked write to 0x10 (holding 0xDEADBEEF) with mask 0x0000FFFF, wdata 0x12345678. Required: response 0xDEADBEEF; subsequent read 0xDEAD5678.
3. LAT=3, back-to-back reads of 0x0, 0x4, 0x8 with resp_ready low cycles 4-5. Required:
   - req_ready = 0 during the stall
   - responses in order, each held stable while stalled
   - no loss or duplication
4. Reset asserted with two reads in flight. Required: resp_valid = 0 the cycle after; no stale responses afterwards; earlier written data still readable.
5. PIPELINED_MEMORY_ALIGN_ERR_EN defined: write addr 0x11. Required: resp_err = 1, rdata = 0, memory unchanged.
   - Undefined: same access writes word 0x10, resp_err = 0.
6. Write to top word 0xFFC, then read 0xFFC. Required: data returned correct; word 0x0 unchanged.

Source files
------------

// File: rtl/pipelined_memory_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_memory_pkg
// Shared sizing helpers for the pipelined data memory.
//   bytes_per_word(w)  : B = W/8
//   byte_off_width(w)  : number of byte-offset address bits, log2(B)
//   addr_width(w, m)   : full byte-address width, log2(B) + M
//   lat_legal(lat)     : 1 when the read latency is in LAT_MIN..LAT_MAX
// The response payload struct depends on W, so each including module builds
// it from its own W-sized word typedef.
// -----------------------------------------------------------------------------
package pipelined_memory_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  function automatic int bytes_per_word(input int w);
    return w / 8;
  endfunction

  function automatic int byte_off_width(input int w);
    return $clog2(w / 8);
  endfunction

  function automatic int addr_width(input int w, input int m);
    return $clog2(w / 8) + m;
  endfunction

  function automatic bit lat_legal(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/pipelined_memory_stage.sv
// -----------------------------------------------------------------------------
// mem_pipe_stage
// One response pipeline register: a valid bit plus a payload of type T.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, clears valid and payload
//   stall     : hold both valid and payload when high
//   in_valid  : valid from the previous stage (or the accept logic)
//   in_data   : payload from the previous stage
//   out_valid : registered valid
//   out_data  : registered payload
// -----------------------------------------------------------------------------
module mem_pipe_stage #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic in_valid,
  input  T     in_data,
  output logic out_valid,
  output T     out_data
);

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the chain shifts by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      // Bubbles are shifted like any other entry; nothing is collapsed.
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/pipelined_memory.sv
// -----------------------------------------------------------------------------
// pipelined_memory
// Byte-addressed, big-endian data memory with bit-masked writes and a LAT-deep
// in-order response pipeline. Writes return the pre-write word.
//
// Parameters: W (word width, multiple of 8), M (log2 word count),
//             LAT (request accept to response valid, 1..4).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid / req_ready    : request handshake
//   req_we, req_addr         : 1 = write; byte address (log2(B)+M bits)
//   req_mask, req_wdata      : per-bit write mask (1 = overwrite), write data
//   resp_valid / resp_ready  : response handshake
//   resp_rdata, resp_err     : read data or pre-write word; misalignment flag
//
// Optional feature macro: PIPELINED_MEMORY_ALIGN_ERR_EN
//   defined   : an access with nonzero byte-offset bits is accepted but makes
//               no storage change and responds with rdata = 0, err = 1.
//   undefined : byte-offset bits are ignored and resp_err is always 0.
// -----------------------------------------------------------------------------
module pipelined_memory
  import pipelined_memory_pkg::*;
#(
  parameter int W   = 32,
  parameter int M   = 10,
  parameter int LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [addr_width(W, M)-1:0] req_addr,
  input  logic [W-1:0]                req_mask,
  input  logic [W-1:0]                req_wdata,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [W-1:0]                resp_rdata,
  output logic                        resp_err
);

  localparam int B      = bytes_per_word(W);
  localparam int LB     = byte_off_width(W);
  localparam int AW     = addr_width(W, M);
  localparam int NBYTES = B * (2 ** M);

  if (!lat_legal(LAT)) begin : g_bad_lat
    $error("pipelined_memory: LAT must be in 1..4");
  end

  typedef logic [W-1:0] word_t;
  typedef struct packed {
    logic  err;
    word_t rdata;
  } mem_resp_t;

  // Storage starts all-zero at elaboration.
  logic [7:0] mem [NBYTES] = '{default: 8'h00};

  logic          stall;
  logic          accept;
  logic          misaligned;
  logic          do_write;
  logic [AW-1:0] base;
  word_t         rd_word;
  mem_resp_t     head;

  mem_resp_t     stage_data  [LAT+1];
  logic          stage_valid [LAT+1];

  assign stall     = resp_valid && !resp_ready;
  assign req_ready = !rst && !stall;
  assign accept    = req_valid && req_ready;
  assign base      = {req_addr[AW-1:LB], {LB{1'b0}}};

`ifdef PIPELINED_MEMORY_ALIGN_ERR_EN
  assign misaligned = (req_addr[LB-1:0] != '0);
`else
  logic unused_byte_offset;
  assign unused_byte_offset = ^req_addr[LB-1:0];
  assign misaligned         = 1'b0;
`endif

  assign do_write = accept && req_we && !misaligned;

  // Big-endian assembly: the byte at the word base lands in the top byte lane.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < B; i++) begin
      rd_word[W-1-8*i -: 8] = mem[base + AW'(i)];
    end
  end

  always_comb begin
    head       = '0;
    head.err   = misaligned;
    head.rdata = misaligned ? '0 : rd_word;
  end

  // rd_word is sampled before this edge's write lands, so a write's response
  // carries the pre-write word, and a read the following cycle sees new data.
  // NOTE: the storage array has no reset branch; rst only gates writes via
  // req_ready, so committed data survives reset and the array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < B; i++) begin
        mem[base + AW'(i)] <= (mem[base + AW'(i)] & ~req_mask[W-1-8*i -: 8])
                            | (req_wdata[W-1-8*i -: 8] & req_mask[W-1-8*i -: 8]);
      end
    end
  end

  assign stage_valid[0] = accept;
  assign stage_data[0]  = head;

  for (genvar g = 0; g < LAT; g++) begin : g_stage
    mem_pipe_stage #(.T(mem_resp_t)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .in_valid  (stage_valid[g]),
      .in_data   (stage_data[g]),
      .out_valid (stage_valid[g+1]),
      .out_data  (stage_data[g+1])
    );
  end

  assign resp_valid = stage_valid[LAT];
  assign resp_rdata = stage_data[LAT].rdata;
  assign resp_err   = stage_data[LAT].err;

endmodule

// File: tb/tb_pipelined_memory.sv
// -----------------------------------------------------------------------------
// tb_pipelined_memory
// Directed bench for pipelined_memory: a LAT=1 instance (dut1) for data,
// mask, byte-order, ordering and alignment behaviour, and a LAT=3 instance
// (dut3) for stall and reset-in-flight behaviour. Follows the
// PIPELINED_MEMORY_ALIGN_ERR_EN macro for its alignment expectations.
// -----------------------------------------------------------------------------
module tb_pipelined_memory;

  logic clk = 1'b0;
  logic rst;

  logic        r1_valid, r1_ready, r1_we;
  logic [11:0] r1_addr;
  logic [31:0] r1_mask, r1_wdata;
  logic        s1_valid, s1_ready, s1_err;
  logic [31:0] s1_rdata;

  logic        r3_valid, r3_ready, r3_we;
  logic [11:0] r3_addr;
  logic [31:0] r3_mask, r3_wdata;
  logic        s3_valid, s3_ready, s3_err;
  logic [31:0] s3_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_memory #(.W(32), .M(10), .LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(r1_valid), .req_ready(r1_ready), .req_we(r1_we),
    .req_addr(r1_addr), .req_mask(r1_mask), .req_wdata(r1_wdata),
    .resp_valid(s1_valid), .resp_ready(s1_ready),
    .resp_rdata(s1_rdata), .resp_err(s1_err)
  );

  pipelined_memory #(.W(32), .M(10), .LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(r3_valid), .req_ready(r3_ready), .req_we(r3_we),
    .req_addr(r3_addr), .req_mask(r3_mask), .req_wdata(r3_wdata),
    .resp_valid(s3_valid), .resp_ready(s3_ready),
    .resp_rdata(s3_rdata), .resp_err(s3_err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction on dut1; lat counts edges from accept to resp_valid.
  task automatic xact1(input logic we, input logic [11:0] a, input logic [31:0] m,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic er, output int lat);
    @(negedge clk);
    r1_valid = 1'b1; r1_we = we; r1_addr = a; r1_mask = m; r1_wdata = d;
    @(posedge clk);
    #1 r1_valid = 1'b0; r1_we = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!s1_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = s1_rdata; er = s1_err;
  endtask

  task automatic xact3(input logic we, input logic [11:0] a, input logic [31:0] m,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic er, output int lat);
    @(negedge clk);
    r3_valid = 1'b1; r3_we = we; r3_addr = a; r3_mask = m; r3_wdata = d;
    @(posedge clk);
    #1 r3_valid = 1'b0; r3_we = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!s3_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = s3_rdata; er = s3_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        stale;

    rst = 1'b1;
    r1_valid = 0; r1_we = 0; r1_addr = '0; r1_mask = '0; r1_wdata = '0; s1_ready = 1;
    r3_valid = 0; r3_we = 0; r3_addr = '0; r3_mask = '0; r3_wdata = '0; s3_ready = 1;

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready1", r1_ready, 1'b0);
    check("rst_req_ready3", r3_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", s1_valid, 1'b0);
    check("post_rst_rdata", s1_rdata, 32'h0);
    check("post_rst_err", s1_err, 1'b0);
    check("post_rst_ready", r1_ready, 1'b1);

    // Full write then read; pre-write word is zero
    xact1(1'b1, 12'h010, 32'hFFFF_FFFF, 32'hDEAD_BEEF, rd, er, lat);
    check("w10_lat", lat, 1);
    check("w10_old", rd, 32'h0);
    check("w10_err", er, 1'b0);
    check("byte10", dut1.mem[16], 8'hDE);
    check("byte13", dut1.mem[19], 8'hEF);
    xact1(1'b0, 12'h010, 32'h0, 32'h0, rd, er, lat);
    check("r10_lat", lat, 1);
    check("r10_data", rd, 32'hDEAD_BEEF);

    // Masked write keeps the upper half
    xact1(1'b1, 12'h010, 32'h0000_FFFF, 32'h1234_5678, rd, er, lat);
    check("mw10_old", rd, 32'hDEAD_BEEF);
    xact1(1'b0, 12'h010, 32'h0, 32'h0, rd, er, lat);
    check("mw10_read", rd, 32'hDEAD_5678);
    check("byte12", dut1.mem[18], 8'h56);

    // Write immediately followed by a read of the same word
    @(posedge clk);
    #1 r1_valid = 1; r1_we = 1; r1_addr = 12'h020; r1_mask = 32'hFFFF_FFFF; r1_wdata = 32'hAAAA_5555;
    @(posedge clk);
    #1 r1_we = 0;
    @(negedge clk);
    check("b2b_w_valid", s1_valid, 1'b1);
    check("b2b_w_old", s1_rdata, 32'h0);
    @(posedge clk);
    #1 r1_valid = 0;
    @(negedge clk);
    check("b2b_r_valid", s1_valid, 1'b1);
    check("b2b_r_data", s1_rdata, 32'hAAAA_5555);

    // Misaligned accesses
    xact1(1'b1, 12'h011, 32'hFFFF_FFFF, 32'hCAFE_F00D, rd, er, lat);
`ifdef PIPELINED_MEMORY_ALIGN_ERR_EN
    check("mis_w_err", er, 1'b1);
    check("mis_w_data", rd, 32'h0);
    xact1(1'b0, 12'h010, 32'h0, 32'h0, rd, er, lat);
    check("mis_w_unchanged", rd, 32'hDEAD_5678);
    xact1(1'b0, 12'h012, 32'h0, 32'h0, rd, er, lat);
    check("mis_r_err", er, 1'b1);
    check("mis_r_data", rd, 32'h0);
`else
    check("mis_w_err", er, 1'b0);
    check("mis_w_old", rd, 32'hDEAD_5678);
    xact1(1'b0, 12'h010, 32'h0, 32'h0, rd, er, lat);
    check("mis_w_written", rd, 32'hCAFE_F00D);
    xact1(1'b0, 12'h012, 32'h0, 32'h0, rd, er, lat);
    check("mis_r_err", er, 1'b0);
    check("mis_r_data", rd, 32'hCAFE_F00D);
`endif

    // Top word
    xact1(1'b1, 12'hFFC, 32'hFFFF_FFFF, 32'h0BAD_F00D, rd, er, lat);
    check("top_w_old", rd, 32'h0);
    xact1(1'b0, 12'hFFC, 32'h0, 32'h0, rd, er, lat);
    check("top_r_data", rd, 32'h0BAD_F00D);
    check("byte_fff", dut1.mem[4095], 8'h0D);
    xact1(1'b0, 12'h000, 32'h0, 32'h0, rd, er, lat);
    check("word0_zero", rd, 32'h0);

    // LAT=3: preload three words
    xact3(1'b1, 12'h000, 32'hFFFF_FFFF, 32'h1111_1111, rd, er, lat);
    check("l3_w0_lat", lat, 3);
    xact3(1'b1, 12'h004, 32'hFFFF_FFFF, 32'h2222_2222, rd, er, lat);
    xact3(1'b1, 12'h008, 32'hFFFF_FFFF, 32'h3333_3333, rd, er, lat);
    xact3(1'b0, 12'h004, 32'h0, 32'h0, rd, er, lat);
    check("l3_r4_lat", lat, 3);
    check("l3_r4_data", rd, 32'h2222_2222);

    // Back-to-back reads with resp_ready low for two cycles
    @(posedge clk);
    #1 r3_valid = 1; r3_we = 0; r3_addr = 12'h000;
    @(posedge clk);
    #1 r3_addr = 12'h004;
    @(posedge clk);
    #1 r3_addr = 12'h008;
    @(posedge clk);
    #1 r3_valid = 0; s3_ready = 0;
    @(negedge clk);
    check("stall1_ready", r3_ready, 1'b0);
    check("stall1_valid", s3_valid, 1'b1);
    check("stall1_data", s3_rdata, 32'h1111_1111);
    @(posedge clk);
    @(negedge clk);
    check("stall2_ready", r3_ready, 1'b0);
    check("stall2_data", s3_rdata, 32'h1111_1111);
    @(posedge clk);
    #1 s3_ready = 1;
    @(negedge clk);
    check("drain0_ready", r3_ready, 1'b1);
    check("drain0_valid", s3_valid, 1'b1);
    check("drain0_data", s3_rdata, 32'h1111_1111);
    @(negedge clk);
    check("drain1_valid", s3_valid, 1'b1);
    check("drain1_data", s3_rdata, 32'h2222_2222);
    @(negedge clk);
    check("drain2_valid", s3_valid, 1'b1);
    check("drain2_data", s3_rdata, 32'h3333_3333);
    @(negedge clk);
    check("drain_empty", s3_valid, 1'b0);

    // Reset with two reads in flight
    @(posedge clk);
    #1 r3_valid = 1; r3_addr = 12'h004;
    @(posedge clk);
    #1 r3_addr = 12'h008;
    @(posedge clk);
    #1 r3_valid = 0; rst = 1;
    @(negedge clk);
    check("mid_rst_ready", r3_ready, 1'b0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("mid_rst_valid", s3_valid, 1'b0);
    check("mid_rst_rdata", s3_rdata, 32'h0);
    check("mid_rst_err", s3_err, 1'b0);
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (s3_valid) stale = 1'b1;
    end
    check("no_stale_resp", stale, 1'b0);
    xact3(1'b0, 12'h008, 32'h0, 32'h0, rd, er, lat);
    check("after_rst_lat", lat, 3);
    check("after_rst_data", rd, 32'h3333_3333);

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
